sprite_frame_scheduler: RTL and testbench
=========================================

Name: sprite_frame_scheduler

Overview:
Upstream sequencer for the sprite drawing blocks (player ship, alien rows, bullets). It derives a fixed-rate frame tick from clk. On each tick it walks the sprite clients in index order, issuing each an erase pass and then a draw pass through per-client erase/draw levels. It also multiplexes the active client's pixel stream (x, y, colour) onto the single VGA adapter port with a plot strobe.

Parameters:
NUM_CLIENTS, 4, number of sprite clients; client 0 is the player ship.
FRAME_CYCLES, 833333, clk cycles per frame (50 MHz / 60 Hz); must be at least 2.
DRAW_CYCLES, 64, cycles draw_out is held high per client; must cover client load and pixel pass (ship needs 44).
TIMEOUT_CYCLES, 256, maximum cycles erase_out is held while waiting for finish_in.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  game-running qualifier, sampled at frame tick
finish_in  in  NUM_CLIENTS  per-client erase-complete level/pulse
x_in  in  9*NUM_CLIENTS  client pixel x, client i at bits [9i+8:9i]
y_in  in  8*NUM_CLIENTS  client pixel y, client i at bits [8i+7:8i]
colour_in  in  3*NUM_CLIENTS  client pixel colour, client i at bits [3i+2:3i]
draw_out  out  NUM_CLIENTS  per-client draw_signal level
erase_out  out  NUM_CLIENTS  per-client erase_signal level
vga_x  out  9  pixel x to VGA adapter
vga_y  out  8  pixel y to VGA adapter
vga_colour  out  3  pixel colour to VGA adapter
vga_plot  out  1  pixel write enable
frame_tick  out  1  one-cycle pulse at each frame boundary
busy  out  1  high while a frame sequence is in progress
overrun  out  1  sticky; set when a tick arrives while one is already pending

Behaviour:
- Reset (reset==0 at posedge): every output is 0, frame counter is 0, FSM is IDLE, client index is 0, all drawn[i] flags are cleared, pending is cleared, overrun is cleared. Reset applies immediately, including mid-sequence.
- Frame counter: counts 0..FRAME_CYCLES-1 and wraps. frame_tick is registered and high for the single cycle after the counter equals FRAME_CYCLES-1.
- Tick acceptance: a tick with enable==1 sets pending. A tick with enable==0 is ignored. If a tick arrives while pending is already 1, overrun is set and the extra tick is dropped; at most one tick is ever queued.
- FSM states: IDLE, ERASE, DRAW, NEXT.
- IDLE: if pending, clear pending, set idx=0, set busy=1, then go to ERASE if drawn[0] is set, else to DRAW.
- ERASE: erase_out[idx]=1. Leave ERASE when finish_in[idx] is sampled 1 or when the erase timer reaches TIMEOUT_CYCLES-1. On leaving, erase_out[idx] drops the next cycle, then go to DRAW.
- DRAW: draw_out[idx]=1 for exactly DRAW_CYCLES cycles (rising edge produces the client's position update), then drop it, set drawn[idx]=1, and go to NEXT.
- NEXT: if idx==NUM_CLIENTS-1, set busy=0 and go to IDLE. Otherwise increment idx and go to ERASE if drawn[idx+1] is set, else to DRAW.
- Exclusivity: at most one bit of draw_out|erase_out is high in any cycle. draw_out[i] and erase_out[i] are never high together. There is at least one cycle with both low between erase and draw of the same client.
- VGA mux: registered, 1-cycle latency. vga_x, vga_y and vga_colour equal the slices of client idx from the previous cycle. vga_plot equals (state was ERASE or DRAW) in the previous cycle. In IDLE and NEXT, vga_plot=0 and the coordinate/colour outputs hold their last values.
- First frame after reset: drawn[] is all 0, so every client gets a draw pass only, no erase.
- Widths: idx is clog2(NUM_CLIENTS) bits (minimum 1). The erase timer and draw timer are clog2 of their parameter plus 1 bit. Counters saturate or clear on state exit and never wrap inside a state.

Test Plan:
- Reset then run, FRAME_CYCLES=200, NUM_CLIENTS=2 -> frame_tick pulses at cycles 200, 400, 600; first sequence shows draw_out[0] high 64 cycles, then draw_out[1] high 64 cycles, with erase_out staying 0.
- Second frame, client 0 asserts finish_in 45 cycles after erase_out[0] rises -> erase_out[0] falls 1 cycle later, draw_out[0] rises on the following cycle, and drawn flags stay set.
- Client 1 never asserts finish_in with TIMEOUT_CYCLES=256 -> erase_out[1] held exactly 256 cycles, then its draw pass proceeds and overrun stays 0.
- FRAME_CYCLES=100 with 4 clients each drawing 64 cycles -> overrun set by the second queued tick, and exactly one pending sequence starts immediately after busy falls.
- Mux check: x_in client 0 = 9'd150, y_in = 8'd200, colour_in = 3'b111 during DRAW -> vga_x=150, vga_y=200, vga_colour=7, vga_plot=1 one cycle later.
- reset driven low mid-ERASE on client 1 -> next cycle all outputs are 0 and the following frame draws all clients with no erase pass.

Source files
------------

// File: rtl/sprite_frame_scheduler_if.sv
// sprite_frame_scheduler_if: client handshake and VGA pixel bundle for the frame scheduler
`timescale 1ns/1ps
interface sprite_frame_scheduler_if #(
  parameter int NUM_CLIENTS = 4
);
  logic                     enable;
  logic [NUM_CLIENTS-1:0]   finish_in;
  logic [9*NUM_CLIENTS-1:0] x_in;
  logic [8*NUM_CLIENTS-1:0] y_in;
  logic [3*NUM_CLIENTS-1:0] colour_in;
  logic [NUM_CLIENTS-1:0]   draw_out;
  logic [NUM_CLIENTS-1:0]   erase_out;
  logic [8:0]               vga_x;
  logic [7:0]               vga_y;
  logic [2:0]               vga_colour;
  logic                     vga_plot;
  logic                     frame_tick;
  logic                     busy;
  logic                     overrun;
  modport master (
    output enable, finish_in, x_in, y_in, colour_in,
    input  draw_out, erase_out, vga_x, vga_y, vga_colour, vga_plot, frame_tick, busy, overrun
  );
  modport slave (
    input  enable, finish_in, x_in, y_in, colour_in,
    output draw_out, erase_out, vga_x, vga_y, vga_colour, vga_plot, frame_tick, busy, overrun
  );
endinterface

// File: rtl/sprite_frame_scheduler.sv
// sprite_frame_scheduler: frame-rate tick plus per-client erase/draw sequencing and VGA pixel mux
`timescale 1ns/1ps
module sprite_frame_scheduler #(
  parameter int NUM_CLIENTS    = 4,
  parameter int FRAME_CYCLES   = 833333,
  parameter int DRAW_CYCLES    = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk,
  input logic reset,
  sprite_frame_scheduler_if.slave bus
);
  localparam int IW = NUM_CLIENTS > 1 ? $clog2(NUM_CLIENTS) : 1;
  localparam int FW = $clog2(FRAME_CYCLES);
  localparam int EW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int DW = $clog2(DRAW_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, NEXT} state_t;
  state_t                 state_q, state_d;
  logic [FW-1:0]          frame_q, frame_d;
  logic                   tick_q, tick_d;
  logic                   pending_q, pending_d;
  logic                   overrun_q, overrun_d;
  logic [IW-1:0]          idx_q, idx_d, nidx;
  logic [NUM_CLIENTS-1:0] drawn_q, drawn_d;
  logic [EW-1:0]          ecnt_q, ecnt_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [8:0]             vx_q;
  logic [7:0]             vy_q;
  logic [2:0]             vc_q;
  logic                   plot_q, plot, accept;
  assign frame_d   = (frame_q == FW'(FRAME_CYCLES - 1)) ? '0 : frame_q + 1'b1;
  assign tick_d    = frame_q == FW'(FRAME_CYCLES - 1);
  assign accept    = tick_q & bus.enable;
  // A tick landing on a queued tick is dropped, so at most one sequence waits.
  assign pending_d = (accept & ~pending_q) | (pending_q & (state_q != IDLE));
  assign overrun_d = overrun_q | (accept & pending_q);
  assign nidx      = idx_q + 1'b1;
  assign plot      = (state_q == ERASE) || (state_q == DRAW);
  // Next-state: walk clients in order, erase only those already drawn once
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drawn_d = drawn_q;
    ecnt_d  = '0;
    dcnt_d  = '0;
    case (state_q)
      IDLE: if (pending_q) begin
        idx_d   = '0;
        state_d = drawn_q[0] ? ERASE : DRAW;
      end
      ERASE: if (bus.finish_in[idx_q] || ecnt_q == EW'(TIMEOUT_CYCLES - 1)) state_d = DRAW;
             else ecnt_d = ecnt_q + 1'b1;
      DRAW: if (dcnt_q == DW'(DRAW_CYCLES)) begin
        state_d        = NEXT;
        drawn_d[idx_q] = 1'b1;
      end else dcnt_d = dcnt_q + 1'b1;
      NEXT: if (idx_q == IW'(NUM_CLIENTS - 1)) state_d = IDLE;
            else begin
              idx_d   = nidx;
              state_d = drawn_q[nidx] ? ERASE : DRAW;
            end
      default: state_d = IDLE;
    endcase
  end
  // Client levels; DRAW's first cycle is a dead cycle so erase and draw never touch
  always_comb begin
    bus.draw_out         = '0;
    bus.erase_out        = '0;
    bus.draw_out[idx_q]  = (state_q == DRAW) && (dcnt_q != '0);
    bus.erase_out[idx_q] = state_q == ERASE;
  end
  // Registers: frame timing, tick queue, sequencer and the one-cycle VGA mux
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      idx_q     <= '0;
      drawn_q   <= '0;
      ecnt_q    <= '0;
      dcnt_q    <= '0;
      vx_q      <= '0;
      vy_q      <= '0;
      vc_q      <= '0;
      plot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      idx_q     <= idx_d;
      drawn_q   <= drawn_d;
      ecnt_q    <= ecnt_d;
      dcnt_q    <= dcnt_d;
      vx_q      <= plot ? bus.x_in[idx_q*9 +: 9] : vx_q;
      vy_q      <= plot ? bus.y_in[idx_q*8 +: 8] : vy_q;
      vc_q      <= plot ? bus.colour_in[idx_q*3 +: 3] : vc_q;
      plot_q    <= plot;
    end
  end
  assign bus.vga_x      = vx_q;
  assign bus.vga_y      = vy_q;
  assign bus.vga_colour = vc_q;
  assign bus.vga_plot   = plot_q;
  assign bus.frame_tick = tick_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// tb_sprite_frame_scheduler: vector table, scripted corner sequences and event scoreboard
`timescale 1ns/1ps
module tb_sprite_frame_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reset2 = 1'b0;
  int   cyc = 0;
  int   cyc2 = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   done2 = 1'b0;
  logic [3:0] prev = '0;
  typedef struct { int cyc; logic [1:0] d; logic [1:0] e; } ev_t;
  typedef struct { int at; logic [17:0] x; logic [15:0] y; logic [5:0] c; logic [8:0] ex; logic [7:0] ey; logic [2:0] ec; } vec_t;
  ev_t  exp_ev[$];
  int   exp_tick[$];
  ev_t  ev_cur;
  vec_t vt[8];
  always #5 clk = ~clk;
  sprite_frame_scheduler_if #(.NUM_CLIENTS(2)) b1();
  sprite_frame_scheduler_if #(.NUM_CLIENTS(4)) b2();
  sprite_frame_scheduler #(.NUM_CLIENTS(2), .FRAME_CYCLES(200), .DRAW_CYCLES(64), .TIMEOUT_CYCLES(256))
    dut (.clk(clk), .reset(reset), .bus(b1));
  sprite_frame_scheduler #(.NUM_CLIENTS(4), .FRAME_CYCLES(100), .DRAW_CYCLES(64), .TIMEOUT_CYCLES(256))
    dut2 (.clk(clk), .reset(reset2), .bus(b2));
  always @(posedge clk) cyc <= reset ? cyc + 1 : 0;
  always @(posedge clk) cyc2 <= reset2 ? cyc2 + 1 : 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (cyc %0d): got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    while (cyc != n) @(negedge clk);
  endtask
  task automatic wait_cyc2(input int n);
    while (cyc2 != n) @(negedge clk);
  endtask
  task automatic push_ev(input int c, input logic [1:0] d, input logic [1:0] e);
    exp_ev.push_back('{c, d, e});
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_draw"}, 32'(b1.draw_out), 0);
    chk({tag, "_erase"}, 32'(b1.erase_out), 0);
    chk({tag, "_vga_x"}, 32'(b1.vga_x), 0);
    chk({tag, "_vga_y"}, 32'(b1.vga_y), 0);
    chk({tag, "_vga_colour"}, 32'(b1.vga_colour), 0);
    chk({tag, "_vga_plot"}, 32'(b1.vga_plot), 0);
    chk({tag, "_frame_tick"}, 32'(b1.frame_tick), 0);
    chk({tag, "_busy"}, 32'(b1.busy), 0);
    chk({tag, "_overrun"}, 32'(b1.overrun), 0);
  endtask
  always @(negedge clk) if (mon_en) begin
    if ({b1.draw_out, b1.erase_out} !== prev) begin
      if (exp_ev.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event at cyc %0d: draw=%b erase=%b", cyc, b1.draw_out, b1.erase_out);
      end else begin
        ev_cur = exp_ev.pop_front();
        chk("event_cycle", 32'(cyc), 32'(ev_cur.cyc));
        chk("event_draw", 32'(b1.draw_out), 32'(ev_cur.d));
        chk("event_erase", 32'(b1.erase_out), 32'(ev_cur.e));
      end
      prev = {b1.draw_out, b1.erase_out};
    end
    if (b1.frame_tick !== 1'b0) begin
      if (exp_tick.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_tick at cyc %0d", cyc);
      end else chk("frame_tick_cycle", 32'(cyc), 32'(exp_tick.pop_front()));
    end
  end
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    b1.enable = 1'b0;
    b1.finish_in = '0;
    b1.x_in = '0;
    b1.y_in = '0;
    b1.colour_in = '0;
    vt[0] = '{210, {9'd5, 9'd150}, {8'd9, 8'd200}, {3'd1, 3'd7}, 9'd150, 8'd200, 3'd7};
    vt[1] = '{214, {9'd300, 9'd0}, {8'd255, 8'd0}, {3'd6, 3'd0}, 9'd0, 8'd0, 3'd0};
    vt[2] = '{218, {9'd0, 9'd511}, {8'd0, 8'd255}, {3'd0, 3'd5}, 9'd511, 8'd255, 3'd5};
    vt[3] = '{222, {9'd256, 9'd1}, {8'd128, 8'd64}, {3'd3, 3'd2}, 9'd1, 8'd64, 3'd2};
    vt[4] = '{280, {9'd77, 9'd150}, {8'd33, 8'd200}, {3'd4, 3'd7}, 9'd77, 8'd33, 3'd4};
    vt[5] = '{290, {9'd511, 9'd3}, {8'd255, 8'd3}, {3'd7, 3'd3}, 9'd511, 8'd255, 3'd7};
    vt[6] = '{300, {9'd0, 9'd400}, {8'd1, 8'd2}, {3'd2, 3'd1}, 9'd0, 8'd1, 3'd2};
    vt[7] = '{320, {9'd77, 9'd150}, {8'd99, 8'd200}, {3'd5, 3'd7}, 9'd77, 8'd99, 3'd5};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    foreach (vt[i]) if (i < 7) exp_tick.push_back(200 * (i + 1));
    exp_tick.push_back(200);
    push_ev(203, 2'b01, 2'b00);
    push_ev(267, 2'b00, 2'b00);
    push_ev(269, 2'b10, 2'b00);
    push_ev(333, 2'b00, 2'b00);
    prev = '0;
    reset = 1'b1;
    b1.enable = 1'b1;
    mon_en = 1'b1;
    wait_cyc(201);
    chk("busy_before_seq", 32'(b1.busy), 0);
    wait_cyc(202);
    chk("busy_seq_start", 32'(b1.busy), 1);
    for (int i = 0; i < 8; i++) begin
      wait_cyc(vt[i].at);
      b1.x_in = vt[i].x;
      b1.y_in = vt[i].y;
      b1.colour_in = vt[i].c;
      @(negedge clk);
      chk("vga_x", 32'(b1.vga_x), 32'(vt[i].ex));
      chk("vga_y", 32'(b1.vga_y), 32'(vt[i].ey));
      chk("vga_colour", 32'(b1.vga_colour), 32'(vt[i].ec));
      chk("vga_plot", 32'(b1.vga_plot), 1);
    end
    wait_cyc(333);
    chk("busy_in_last_next", 32'(b1.busy), 1);
    wait_cyc(334);
    chk("busy_after_seq", 32'(b1.busy), 0);
    wait_cyc(341);
    b1.x_in = '1;
    b1.y_in = '1;
    b1.colour_in = '1;
    wait_cyc(345);
    chk("hold_vga_x", 32'(b1.vga_x), 77);
    chk("hold_vga_y", 32'(b1.vga_y), 99);
    chk("hold_vga_colour", 32'(b1.vga_colour), 5);
    chk("hold_vga_plot", 32'(b1.vga_plot), 0);
    push_ev(402, 2'b00, 2'b01);
    push_ev(448, 2'b00, 2'b00);
    push_ev(449, 2'b01, 2'b00);
    push_ev(513, 2'b00, 2'b00);
    push_ev(514, 2'b00, 2'b10);
    push_ev(770, 2'b00, 2'b00);
    push_ev(771, 2'b10, 2'b00);
    push_ev(835, 2'b00, 2'b00);
    wait_cyc(447);
    b1.finish_in = 2'b01;
    wait_cyc(448);
    b1.finish_in = 2'b00;
    chk("gap_erase", 32'(b1.erase_out), 0);
    chk("gap_draw", 32'(b1.draw_out), 0);
    wait_cyc(450);
    b1.enable = 1'b0;
    wait_cyc(836);
    chk("busy_frame2_done", 32'(b1.busy), 0);
    chk("overrun_after_timeout", 32'(b1.overrun), 0);
    wait_cyc(900);
    b1.enable = 1'b1;
    push_ev(1002, 2'b00, 2'b01);
    push_ev(1258, 2'b00, 2'b00);
    push_ev(1259, 2'b01, 2'b00);
    push_ev(1323, 2'b00, 2'b00);
    push_ev(1324, 2'b00, 2'b10);
    push_ev(0, 2'b00, 2'b00);
    wait_cyc(1010);
    b1.enable = 1'b0;
    wait_cyc(1400);
    chk("mid_erase_client1", 32'(b1.erase_out), 2);
    chk("mid_erase_busy", 32'(b1.busy), 1);
    reset = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    @(negedge clk);
    push_ev(203, 2'b01, 2'b00);
    push_ev(267, 2'b00, 2'b00);
    push_ev(269, 2'b10, 2'b00);
    push_ev(333, 2'b00, 2'b00);
    reset = 1'b1;
    b1.enable = 1'b1;
    wait_cyc(340);
    chk("post_reset_idle_draw", 32'(b1.draw_out), 0);
    chk("post_reset_overrun", 32'(b1.overrun), 0);
    chk("events_left", 32'(exp_ev.size()), 0);
    chk("ticks_left", 32'(exp_tick.size()), 0);
    for (int i = 0; i < 1000 && !done2; i++) @(negedge clk);
    chk("overrun_bench_done", 32'(done2), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    b2.enable = 1'b0;
    b2.finish_in = '0;
    b2.x_in = '0;
    b2.y_in = '0;
    b2.colour_in = '0;
    repeat (3) @(negedge clk);
    reset2 = 1'b1;
    b2.enable = 1'b1;
    wait_cyc2(101);
    chk("ov_busy_101", 32'(b2.busy), 0);
    wait_cyc2(102);
    chk("ov_busy_102", 32'(b2.busy), 1);
    wait_cyc2(103);
    chk("ov_draw0_103", 32'(b2.draw_out), 1);
    wait_cyc2(300);
    chk("ov_overrun_300", 32'(b2.overrun), 0);
    wait_cyc2(301);
    chk("ov_overrun_301", 32'(b2.overrun), 1);
    wait_cyc2(365);
    chk("ov_busy_365", 32'(b2.busy), 1);
    chk("ov_draw_365", 32'(b2.draw_out), 0);
    wait_cyc2(366);
    chk("ov_busy_366", 32'(b2.busy), 0);
    chk("ov_erase_366", 32'(b2.erase_out), 0);
    wait_cyc2(367);
    chk("ov_busy_367", 32'(b2.busy), 1);
    chk("ov_erase_367", 32'(b2.erase_out), 1);
    chk("ov_overrun_sticky", 32'(b2.overrun), 1);
    done2 = 1'b1;
  end
endmodule
